fc_layer: RTL and testbench

Fully connected classifier stage that consumes the pooled feature map written by the second convolution layer. It computes OUT_LEN dot products of length IN_LEN against a weight ROM, adds a per-neuron bias, rescales, saturates, writes each logit to a result memory and tracks the arg-max class. One multiply-accumulate per cycle, one neuron at a time, driven by a start/done handshake from the top-level sequencer.

---
 rtl/fc_layer_if.sv | 45 ++++
 rtl/fc_layer.sv | 172 +++++++++++++++++
 tb/tb_fc_layer.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fc_layer_if.sv
// fc_layer_if: bundles the fc_layer control handshake, the three memory read
// ports (feature RAM, weight ROM, bias ROM), the logit write port and the
// classification result.
//   start/busy/done          : run handshake with the top-level sequencer
//   feat_addr/feat_data      : feature memory read port (1-cycle latency)
//   w_addr/w_data            : weight ROM read port (1-cycle latency)
//   b_addr/b_data            : bias ROM read port (1-cycle latency)
//   res_we/res_addr/res_data : logit write port
//   class_out/score_out      : arg-max class and its logit
// Modports: master = sequencer/memory side, slave = fc_layer.
interface fc_layer_if #(
  parameter int unsigned IN_LEN  = 196,
  parameter int unsigned OUT_LEN = 10
);
  localparam int unsigned FA_W = $clog2(IN_LEN);
  localparam int unsigned WA_W = $clog2(IN_LEN * OUT_LEN);
  localparam int unsigned NA_W = $clog2(OUT_LEN);

  logic                   start;
  logic                   busy;
  logic                   done;
  logic [FA_W-1:0]        feat_addr;
  logic signed [7:0]      feat_data;
  logic [WA_W-1:0]        w_addr;
  logic signed [7:0]      w_data;
  logic [NA_W-1:0]        b_addr;
  logic signed [7:0]      b_data;
  logic                   res_we;
  logic [NA_W-1:0]        res_addr;
  logic signed [7:0]      res_data;
  logic [3:0]             class_out;
  logic signed [7:0]      score_out;

  modport master (
    output start, feat_data, w_data, b_data,
    input  busy, done, feat_addr, w_addr, b_addr,
    input  res_we, res_addr, res_data, class_out, score_out
  );

  modport slave (
    input  start, feat_data, w_data, b_data,
    output busy, done, feat_addr, w_addr, b_addr,
    output res_we, res_addr, res_data, class_out, score_out
  );
endinterface

// File: rtl/fc_layer.sv
// fc_layer: fully connected classifier stage. For each of OUT_LEN neurons it
// accumulates IN_LEN feature*weight products on top of a pre-shifted bias,
// rescales by SHIFT, saturates to 8 bits, writes the logit and tracks the
// arg-max class. One MAC per cycle, one neuron at a time.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : fc_layer_if.slave (handshake, memory read ports, logit write port,
//          class/score result); all outputs are registered.
module fc_layer #(
  parameter int unsigned IN_LEN  = 196,
  parameter int unsigned OUT_LEN = 10,
  parameter int unsigned ACC_W   = 24,
  parameter int unsigned SHIFT   = 7
) (
  input  logic      clk,
  input  logic      rst,
  fc_layer_if.slave bus
);
  localparam int unsigned FA_W = $clog2(IN_LEN);
  localparam int unsigned NA_W = $clog2(OUT_LEN);

  localparam logic [FA_W-1:0] LAST_I = FA_W'(IN_LEN - 1);
  localparam logic [NA_W-1:0] LAST_N = NA_W'(OUT_LEN - 1);

  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(127);
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-128);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAC,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } state_t;

  state_t                  state;
  logic [FA_W-1:0]         idx;
  logic [NA_W-1:0]         nrn;
  logic                    vld;        // read data on the bus this cycle is a live product
  logic                    vld_first;  // ... and it belongs to feature index 0
  logic signed [ACC_W-1:0] acc;
  logic signed [7:0]       best_score;
  logic [NA_W-1:0]         best_class;

  logic signed [15:0]      feat_ext;
  logic signed [15:0]      w_ext;
  logic signed [15:0]      prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] bias_ext;
  logic signed [ACC_W-1:0] acc_base;
  logic signed [ACC_W-1:0] acc_nxt;
  logic signed [ACC_W-1:0] acc_shr;
  logic signed [7:0]       sat;

  // Datapath: product, accumulate (bias seeds the first product), rescale, saturate
  always_comb begin
    feat_ext = 16'(bus.feat_data);
    w_ext    = 16'(bus.w_data);
    prod     = feat_ext * w_ext;
    prod_ext = ACC_W'(prod);
    bias_ext = ACC_W'(bus.b_data) <<< SHIFT;
    acc_base = vld_first ? bias_ext : acc;
    acc_nxt  = acc_base + prod_ext;
    acc_shr  = acc_nxt >>> SHIFT;
    if (acc_shr > SAT_HI) begin
      sat = 8'sh7F;
    end else if (acc_shr < SAT_LO) begin
      sat = 8'sh80;
    end else begin
      sat = acc_shr[7:0];
    end
  end

  // Control FSM with registered outputs. The logit is registered on the DRAIN
  // edge from acc_nxt so it is already valid while res_we is high in WRITE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      idx           <= '0;
      nrn           <= '0;
      vld           <= 1'b0;
      vld_first     <= 1'b0;
      acc           <= '0;
      best_score    <= '0;
      best_class    <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.feat_addr <= '0;
      bus.w_addr    <= '0;
      bus.b_addr    <= '0;
      bus.res_we    <= 1'b0;
      bus.res_addr  <= '0;
      bus.res_data  <= '0;
      bus.class_out <= '0;
      bus.score_out <= '0;
    end else begin
      vld        <= 1'b0;
      vld_first  <= 1'b0;
      bus.res_we <= 1'b0;
      bus.done   <= 1'b0;

      if (vld) begin
        acc <= acc_nxt;
      end

      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state         <= S_MAC;
            bus.busy      <= 1'b1;
            idx           <= '0;
            nrn           <= '0;
            bus.feat_addr <= '0;
            bus.w_addr    <= '0;
            bus.b_addr    <= '0;
          end
        end

        S_MAC: begin
          vld       <= 1'b1;
          vld_first <= (idx == '0);
          if (idx == LAST_I) begin
            state <= S_DRAIN;
          end else begin
            idx           <= idx + 1'b1;
            bus.feat_addr <= idx + 1'b1;
            bus.w_addr    <= bus.w_addr + 1'b1;
          end
        end

        S_DRAIN: begin
          state        <= S_WRITE;
          bus.res_we   <= 1'b1;
          bus.res_addr <= nrn;
          bus.res_data <= sat;
          // Strictly greater keeps the lowest index on ties
          if ((nrn == '0) || (sat > best_score)) begin
            best_score <= sat;
            best_class <= nrn;
          end
        end

        S_WRITE: begin
          if (nrn == LAST_N) begin
            state         <= S_DONE;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b1;
            bus.class_out <= 4'(best_class);
            bus.score_out <= best_score;
          end else begin
            state         <= S_MAC;
            nrn           <= nrn + 1'b1;
            idx           <= '0;
            bus.feat_addr <= '0;
            // weight address runs contiguously across neurons
            bus.w_addr    <= bus.w_addr + 1'b1;
            bus.b_addr    <= nrn + 1'b1;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fc_layer.sv
// tb_fc_layer: scoreboard bench for fc_layer with IN_LEN=4, OUT_LEN=3,
// SHIFT=0. Expected logit writes and done events are pushed when a run is
// launched and popped by a negedge monitor when the DUT produces them.
module tb_fc_layer;
  localparam int IN_LEN  = 4;
  localparam int OUT_LEN = 3;
  localparam int ACC_W   = 24;
  localparam int SHIFT   = 0;
  localparam int PER_N   = IN_LEN + 2;

  typedef struct {
    int a;
    int d;
    int when;
  } exp_t;

  logic clk;
  logic rst;
  int   edges;
  int   checks;
  int   failures;
  int   nwr;

  exp_t wq[$];
  exp_t dq[$];

  logic signed [7:0] feat_mem [IN_LEN];
  logic signed [7:0] w_mem    [IN_LEN*OUT_LEN];
  logic signed [7:0] b_mem    [OUT_LEN];

  fc_layer_if #(.IN_LEN(IN_LEN), .OUT_LEN(OUT_LEN)) bus();

  fc_layer #(
    .IN_LEN (IN_LEN),
    .OUT_LEN(OUT_LEN),
    .ACC_W  (ACC_W),
    .SHIFT  (SHIFT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edges <= edges + 1;

  // Synchronous memories, one-cycle read latency
  always @(posedge clk) begin
    bus.feat_data <= feat_mem[bus.feat_addr];
    bus.w_data    <= w_mem[bus.w_addr];
    bus.b_data    <= b_mem[bus.b_addr];
  end

  task automatic chk(input string tag, input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int logit(int n);
    int acc;
    acc = int'(b_mem[n]) <<< SHIFT;
    for (int i = 0; i < IN_LEN; i++) acc += int'(feat_mem[i]) * int'(w_mem[n*IN_LEN+i]);
    acc = acc >>> SHIFT;
    if (acc > 127) acc = 127;
    if (acc < -128) acc = -128;
    return acc;
  endfunction

  task automatic push_run(input int e0, input int nw, input bit with_done);
    int best;
    int bcls;
    int l;
    best = 0;
    bcls = 0;
    for (int n = 0; n < OUT_LEN; n++) begin
      l = logit(n);
      if (n == 0 || l > best) begin
        best = l;
        bcls = n;
      end
      if (n < nw) wq.push_back('{a: n, d: l, when: e0 + (n+1)*PER_N - 1});
    end
    if (with_done) dq.push_back('{a: bcls, d: best, when: e0 + OUT_LEN*PER_N});
  endtask

  // Returns at the negedge of cycle 1 of the run; e0 is the edge count after E0
  task automatic launch(input bit hold, input int nw, input bit with_done, output int e0);
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    e0 = edges;
    push_run(e0, nw, with_done);
    @(negedge clk);
    if (!hold) bus.start = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (bus.done !== 1'b1 && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (k >= 400) chk("done_timeout", bus.done, 1);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    if (bus.res_we === 1'b1) begin
      nwr++;
      if (wq.size() == 0) begin
        chk("unexp_write", bus.res_we, 0);
      end else begin
        e = wq.pop_front();
        chk("res_addr", bus.res_addr, e.a);
        chk("res_data", bus.res_data, e.d);
        chk("we_cycle", edges, e.when);
        chk("busy_in_write", bus.busy, 1);
      end
    end
    if (bus.done === 1'b1) begin
      if (dq.size() == 0) begin
        chk("unexp_done", bus.done, 0);
      end else begin
        e = dq.pop_front();
        chk("class_out", bus.class_out, e.a);
        chk("score_out", bus.score_out, e.d);
        chk("done_cycle", edges, e.when);
        chk("busy_at_done", bus.busy, 0);
      end
    end
  end

  task automatic set_mem(input int f0, input int f1, input int f2, input int f3,
                         input int w0, input int w1, input int w2,
                         input int b0, input int b1, input int b2);
    feat_mem[0] = 8'(f0);
    feat_mem[1] = 8'(f1);
    feat_mem[2] = 8'(f2);
    feat_mem[3] = 8'(f3);
    for (int i = 0; i < IN_LEN; i++) begin
      w_mem[i]            = 8'(w0);
      w_mem[IN_LEN+i]     = 8'(w1);
      w_mem[2*IN_LEN+i]   = 8'(w2);
    end
    b_mem[0] = 8'(b0);
    b_mem[1] = 8'(b1);
    b_mem[2] = 8'(b2);
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_busy"}, bus.busy, 0);
    chk({pfx, "_done"}, bus.done, 0);
    chk({pfx, "_res_we"}, bus.res_we, 0);
    chk({pfx, "_feat_addr"}, bus.feat_addr, 0);
    chk({pfx, "_w_addr"}, bus.w_addr, 0);
    chk({pfx, "_b_addr"}, bus.b_addr, 0);
    chk({pfx, "_res_addr"}, bus.res_addr, 0);
    chk({pfx, "_res_data"}, bus.res_data, 0);
    chk({pfx, "_class_out"}, bus.class_out, 0);
    chk({pfx, "_score_out"}, bus.score_out, 0);
  endtask

  initial begin
    int e0;
    int w_before;
    checks    = 0;
    failures  = 0;
    nwr       = 0;
    edges     = 0;
    rst       = 1'b0;
    bus.start = 1'b0;
    set_mem(1, 2, 3, 4, 1, -1, 2, 0, 5, 0);
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Basic run with a stray start pulse mid-run
    w_before = nwr;
    launch(1'b0, OUT_LEN, 1'b1, e0);
    chk("busy_cycle1", bus.busy, 1);
    repeat (3) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done();
    @(negedge clk);
    chk("done_width", bus.done, 0);
    chk("busy_after", bus.busy, 0);
    chk("class_hold", bus.class_out, 2);
    chk("writes_per_run", nwr - w_before, OUT_LEN);

    // Reset during neuron 1 MAC: only neuron 0 write expected
    launch(1'b0, 1, 1'b0, e0);
    repeat (7) @(negedge clk);
    chk("mid_busy", bus.busy, 1);
    #2 rst = 1'b0;
    #1 chk_all_zero("midrst");
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    chk("no_write_after_rst", wq.size(), 0);

    // Full run after reset release
    launch(1'b0, OUT_LEN, 1'b1, e0);
    wait_done();

    // Saturation high and low
    set_mem(127, 127, 127, 127, 127, 127, 127, 0, 0, 0);
    launch(1'b0, OUT_LEN, 1'b1, e0);
    wait_done();
    set_mem(127, 127, 127, 127, -128, -128, -128, 0, 0, 0);
    launch(1'b0, OUT_LEN, 1'b1, e0);
    wait_done();

    // Tie between neuron 0 and 2
    set_mem(1, 2, 3, 4, 2, 1, 2, 0, 0, 0);
    launch(1'b0, OUT_LEN, 1'b1, e0);
    wait_done();

    // Start held high: second run starts right after done
    set_mem(1, 2, 3, 4, 1, -1, 2, 0, 5, 0);
    launch(1'b1, OUT_LEN, 1'b1, e0);
    push_run(e0 + OUT_LEN*PER_N + 2, OUT_LEN, 1'b1);
    wait_done();
    @(negedge clk);
    chk("idle_after_done", bus.busy, 0);
    @(negedge clk);
    chk("retrigger_busy", bus.busy, 1);
    bus.start = 1'b0;
    wait_done();

    // Random contents
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < IN_LEN; i++) feat_mem[i] = 8'($urandom_range(0, 40));
      for (int i = 0; i < IN_LEN*OUT_LEN; i++) w_mem[i] = 8'($urandom_range(0, 60) - 30);
      for (int i = 0; i < OUT_LEN; i++) b_mem[i] = 8'($urandom_range(0, 40) - 20);
      launch(1'b0, OUT_LEN, 1'b1, e0);
      wait_done();
    end

    repeat (4) @(negedge clk);
    chk("wq_empty", wq.size(), 0);
    chk("dq_empty", dq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
